adc_ltc2308_ctrl: RTL
=====================

// Module: adc_ltc2308_ctrl
// PURPOSE
//  SPI master for the DE1-SoC LTC2308 12-bit ADC; front end of the synth's analog input path.
//  Runs conversions at a fixed sample rate and drives `data`, which holds between conversions.
//  `data` feeds the downstream smoothing (moving-average) stage, which reads it every clk.
// PARAMETERS
//  CLK_DIV       2     SCK half-period in clk cycles (50 MHz clk -> 12.5 MHz SCK); >=1
//  CONVST_CYCLES 2     adc_convst high time, clk cycles; >=1
//  CONV_CYCLES   80    wait after convst falls before first SCK (1.6 us @50 MHz)
//  SAMPLE_DIV    1000  clk cycles between conversion starts (50 kS/s)
//  SCAN_LAST     7     last channel of the scan (ADC_SCAN_EN only)
// PORTS
//  clk        in   1   system clock, 50 MHz
//  reset_n    in   1   asynchronous, active-low reset
//  enable     in   1   1 = run the sample timer; 0 = hold timer at 0
//  ch_sel     in   3   single-ended channel, read at each start tick
//  adc_convst out  1   LTC2308 CONVST
//  adc_sck    out  1   LTC2308 SCK, idles low
//  adc_sdi    out  1   LTC2308 SDI (6-bit config word, MSB first)
//  adc_sdo    in   1   LTC2308 SDO
//  data       out  12  last completed sample, unsigned straight binary
//  data_valid out  1   1-cycle strobe when data/data_ch update
//  data_ch    out  3   channel of the current data
//  overrun    out  1   sticky: start tick arrived while not IDLE
// BEHAVIOUR
//  Reset (async): every output 0; FSM IDLE; timer 0; shift regs 0. Applies mid-transfer too.
//  Timer: counts 0..SAMPLE_DIV-1 while enable=1; tick = count at SAMPLE_DIV-1, then wraps to 0.
//  Tick in IDLE: latch channel; cfg = {1'b1 (S/D), ch[0] (O/S), ch[2] (S1), ch[1] (S0), 1'b1 (UNI), 1'b0 (SLP)}.
//  Tick outside IDLE: ignored; overrun <= 1 until reset.
//  FSM IDLE -> CONVST -> CONV -> SHIFT -> DONE -> IDLE.
//   CONVST: adc_convst=1 for exactly CONVST_CYCLES cycles.
//   CONV: adc_convst=0; wait CONV_CYCLES cycles.
//   SHIFT: 12 SCK periods of 2*CLK_DIV clk each (low phase, then high phase).
//    - adc_sdi updates at the start of each low phase: cfg[5..0], then 0 for bits 6-11.
//    - adc_sdo is sampled on the clk where SCK rises; MSB first into a 12-bit shift reg.
//   DONE (1 cycle): data <= shift reg; data_ch <= latched ch; data_valid=1.
//  Latency: data_valid is high exactly CONVST_CYCLES+CONV_CYCLES+24*CLK_DIV+1 cycles after the tick cycle.
//  enable dropping mid-conversion: the conversion completes and is delivered; no new tick.
//  SAMPLE_DIV must be >= CONVST_CYCLES+CONV_CYCLES+24*CLK_DIV+2; smaller values cause overrun.
//  data/data_ch hold their values between strobes. adc_sck=0 and adc_sdi=0 outside SHIFT.
// CONFIGURATION
//  ADC_SCAN_EN defined: the latched channel comes from an internal scan counter, not ch_sel.
//   - Counter is reset to 0; advances in DONE; wraps SCAN_LAST -> 0. ch_sel is ignored.
//  ADC_SCAN_EN undefined: channel = ch_sel at the tick; no scan counter is built.
// STRUCTURE
//  Package adc_pkg:
//   - state enum adc_state_t {IDLE, CONVST, CONV, SHIFT, DONE}
//   - ADC_BITS=12, CFG_BITS=6
//   - function ltc2308_cfg(ch) returning the 6-bit word
//  Sub-module adc_tick_gen: SAMPLE_DIV timer with enable, emits the tick.
//  FSM, SCK divider and shift registers stay in the top module.
// TESTING
//  1 Assert reset_n=0 mid-SHIFT -> all outputs 0 in the same cycle; after release, next data_valid >= SAMPLE_DIV cycles later.
//  2 ch_sel=5, SDO model returns 12'hA5C -> SDI bits 1,1,1,0,1,0 then 0s; data=12'hA5C, data_ch=5; 12 SCK rising edges.
//  3 enable held 1 with defaults -> data_valid 2+80+48+1=131 cycles after each tick; strobes every 1000 cycles.
//  4 Drop enable during SHIFT -> that sample is delivered; no further convst or data_valid.
//  5 SAMPLE_DIV=50 with defaults -> overrun=1 on the first colliding tick; every delivered sample still correct.
//  6 ADC_SCAN_EN, SCAN_LAST=7 -> data_ch sequence 0,1,...,7,0; SDI words match ltc2308_cfg for each channel.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared types and helpers for the LTC2308 ADC controller.
package adc_pkg;

   localparam int ADC_BITS = 12;
   localparam int CFG_BITS = 6;

   typedef enum logic [2:0] {
      IDLE,
      CONVST,
      CONV,
      SHIFT,
      DONE
   } adc_state_t;

   // LTC2308 input word for a single-ended, unipolar, awake conversion.
   // Bit order, MSB first: S/D, O/S, S1, S0, UNI, SLP.
   function automatic logic [CFG_BITS-1:0] ltc2308_cfg(input logic [2:0] ch);
      return {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
   endfunction

endpackage

// File: rtl/adc_tick_gen.sv
// Sample-rate timer: counts 0..SAMPLE_DIV-1 while enabled and flags the last count.
// Disabling clears the count, so re-enabling always waits a full period.
module adc_tick_gen #(
   parameter int SAMPLE_DIV = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_enable,
   output logic o_tick
);

   localparam int            CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

   logic [CW-1:0] r_count;
   logic          w_last;

   assign w_last = (r_count == LAST);

   // free-running period counter, held at zero while disabled
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (!i_enable) begin
         r_count <= '0;
      end else if (w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_tick = i_enable && w_last;

endmodule

// File: rtl/adc_ltc2308_ctrl.sv
// SPI master for the LTC2308 12-bit ADC: periodic conversion, 6-bit config
// shifted out on SDI while the 12-bit result is shifted in from SDO.
// Optional build macro ADC_SCAN_EN: channel comes from an internal scan
// counter (0..SCAN_LAST) instead of ch_sel.
module adc_ltc2308_ctrl
   import adc_pkg::*;
#(
   parameter int CLK_DIV       = 2,
   parameter int CONVST_CYCLES = 2,
   parameter int CONV_CYCLES   = 80,
   parameter int SAMPLE_DIV    = 1000
`ifdef ADC_SCAN_EN
  ,parameter int SCAN_LAST     = 7
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic [2:0]  ch_sel,
   output logic        adc_convst,
   output logic        adc_sck,
   output logic        adc_sdi,
   input  logic        adc_sdo,
   output logic [11:0] data,
   output logic        data_valid,
   output logic [2:0]  data_ch,
   output logic        overrun
);

   // one counter serves both the CONVST high time and the CONV wait
   localparam int CNT_MAX = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int DIV_W   = $clog2(CLK_DIV + 1);

   localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(CONVST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [3:0]       BIT_LAST    = 4'(ADC_BITS - 1);

   adc_state_t          r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DIV_W-1:0]    r_div;
   logic [3:0]          r_bit;
   logic [2:0]          r_ch;
   logic [CFG_BITS-1:0] r_sdi_sh;
   logic [ADC_BITS-1:0] r_shift;

   logic                w_tick;
   logic [2:0]          w_ch;

   adc_tick_gen #(
      .SAMPLE_DIV (SAMPLE_DIV)
   ) u_tick (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_enable (enable),
      .o_tick   (w_tick)
   );

`ifdef ADC_SCAN_EN
   localparam logic [2:0] SCAN_WRAP = 3'(SCAN_LAST);

   logic [2:0] r_scan;

   // scan channel steps once per completed conversion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scan <= '0;
      end else if (r_state == DONE) begin
         r_scan <= (r_scan == SCAN_WRAP) ? 3'd0 : r_scan + 3'd1;
      end
   end

   assign w_ch = r_scan;
`else
   assign w_ch = ch_sel;
`endif

   // conversion sequencer, SCK generator and both shift registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_div      <= '0;
         r_bit      <= '0;
         r_ch       <= '0;
         r_sdi_sh   <= '0;
         r_shift    <= '0;
         adc_convst <= 1'b0;
         adc_sck    <= 1'b0;
         adc_sdi    <= 1'b0;
         data       <= '0;
         data_ch    <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         data_valid <= 1'b0;

         // a tick that finds us busy is dropped but remembered
         if (w_tick && (r_state != IDLE)) begin
            overrun <= 1'b1;
         end

         case (r_state)
            IDLE: begin
               if (w_tick) begin
                  r_ch       <= w_ch;
                  r_sdi_sh   <= ltc2308_cfg(w_ch);
                  r_cnt      <= '0;
                  adc_convst <= 1'b1;
                  r_state    <= CONVST;
               end
            end

            CONVST: begin
               if (r_cnt == CONVST_LAST) begin
                  r_cnt      <= '0;
                  adc_convst <= 1'b0;
                  r_state    <= CONV;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            CONV: begin
               if (r_cnt == CONV_LAST) begin
                  // first low phase starts now, so present config MSB
                  r_div    <= '0;
                  r_bit    <= '0;
                  adc_sck  <= 1'b0;
                  adc_sdi  <= r_sdi_sh[CFG_BITS-1];
                  r_sdi_sh <= {r_sdi_sh[CFG_BITS-2:0], 1'b0};
                  r_state  <= SHIFT;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            SHIFT: begin
               if (r_div == DIV_LAST) begin
                  r_div <= '0;
                  if (!adc_sck) begin
                     // rising edge: capture SDO, MSB first
                     adc_sck <= 1'b1;
                     r_shift <= {r_shift[ADC_BITS-2:0], adc_sdo};
                  end else begin
                     adc_sck <= 1'b0;
                     if (r_bit == BIT_LAST) begin
                        // result is complete; publish it during DONE
                        adc_sdi    <= 1'b0;
                        data       <= r_shift;
                        data_ch    <= r_ch;
                        data_valid <= 1'b1;
                        r_state    <= DONE;
                     end else begin
                        // config bits run out into zeros after bit 5
                        r_bit    <= r_bit + 4'd1;
                        adc_sdi  <= r_sdi_sh[CFG_BITS-1];
                        r_sdi_sh <= {r_sdi_sh[CFG_BITS-2:0], 1'b0};
                     end
                  end
               end else begin
                  r_div <= r_div + DIV_W'(1);
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
